// File: rtl/adder_mw_pkg.sv
// Shared definitions for the multi-word adder sequencer: FSM encodings and default geometry.
package adder_mw_pkg;

  localparam int DEF_N = 5;
  localparam int DEF_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_rc.sv
// N-bit ripple-carry adder; the single word-wide adder shared by the sequencer.
module adder_rc #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < N; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[N];

endmodule

// File: rtl/adder_mw_ctrl.sv
// Multi-word adder: W words of N bits summed LSW first through one adder_rc, carry held between words.
// Optional subtract mode and signed overflow flag are enabled by defining ADDER_MW_SUB_EN.
module adder_mw_ctrl
  import adder_mw_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [W*N-1:0] a,
  input  logic [W*N-1:0] b,
  input  logic           ci,
`ifdef ADDER_MW_SUB_EN
  input  logic           sub,
  output logic           ovf,
`endif
  output logic           busy,
  output logic           done,
  output logic [W*N-1:0] s,
  output logic           co,
  output logic [1:0]     state_dbg
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  // Handshake: start is a request honoured only in IDLE (no ready, no queueing);
  // done is a one-cycle valid pulse for {co,s}, which then hold until the next op's RUN.
  state_t               state, state_nxt;
  logic [IW-1:0]        idx;
  logic                 carry;
  logic [W-1:0][N-1:0]  a_reg, b_reg, s_reg;
  logic [N-1:0]         add_a, add_b, add_s;
  logic                 add_co;
  logic                 last;

  assign last  = (idx == IW'(W - 1));
  assign add_a = a_reg[idx];

`ifdef ADDER_MW_SUB_EN
  logic sub_reg;
  // Two's-complement subtract: invert B words, carry-in starts as ~ci.
  assign add_b = b_reg[idx] ^ {N{sub_reg}};
`else
  assign add_b = b_reg[idx];
`endif

  adder_rc #(.N(N)) u_adder (
    .a  (add_a),
    .b  (add_b),
    .ci (carry),
    .s  (add_s),
    .co (add_co)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      s_reg   <= '0;
      co      <= 1'b0;
`ifdef ADDER_MW_SUB_EN
      sub_reg <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= '0;
`ifdef ADDER_MW_SUB_EN
            sub_reg <= sub;
            carry   <= ci ^ sub;
`else
            carry   <= ci;
`endif
          end
        end
        ST_RUN: begin
          s_reg[idx] <= add_s;
          carry      <= add_co;
          idx        <= idx + 1'b1;
          if (last) begin
            co <= add_co;
`ifdef ADDER_MW_SUB_EN
            // Carry into the MSB is recovered from the MSB sum bit.
            ovf <= (add_a[N-1] ^ add_b[N-1] ^ add_s[N-1]) ^ add_co;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign s         = s_reg;
  assign state_dbg = state;

endmodule

// File: tb/tb_adder_mw_ctrl.sv
// Directed bench for adder_mw_ctrl (N=5, W=4) with a closing random sweep; subtract checks under ADDER_MW_SUB_EN.
module tb_adder_mw_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [19:0] a, b;
  logic        ci;
  logic        busy, done, co;
  logic [19:0] s;
  logic [1:0]  state_dbg;
`ifdef ADDER_MW_SUB_EN
  logic        sub;
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  adder_mw_ctrl #(.N(5), .W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .ci        (ci),
`ifdef ADDER_MW_SUB_EN
    .sub       (sub),
    .ovf       (ovf),
`endif
    .busy      (busy),
    .done      (done),
    .s         (s),
    .co        (co),
    .state_dbg (state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start driven just after edge e; done expected after edge e+5, busy seen for 5 cycles.
  task automatic do_op(input string tag, input logic [19:0] ta, input logic [19:0] tb,
                       input logic tci, input logic tsub,
                       input logic [19:0] es, input logic eco, input logic full);
    int dc;
    int bc;
    @(posedge clock); #1;
    a = ta; b = tb; ci = tci; start = 1'b1;
`ifdef ADDER_MW_SUB_EN
    sub = tsub;
`endif
    dc = 0;
    bc = 0;
    for (int c = 1; c <= 20 && dc == 0; c++) begin
      @(posedge clock); #1;
      if (c == 1) begin
        start = 1'b0;
        a = ~ta; b = ~tb; ci = ~tci;
      end
      if (busy) bc++;
      if (done) dc = c;
    end
    if (full) begin
      check({tag, "_latency"}, dc, 5);
      check({tag, "_busy_width"}, bc, 5);
    end else if (dc == 0) begin
      check({tag, "_timeout"}, dc, 5);
    end
    check({tag, "_s"}, s, es);
    check({tag, "_co"}, co, eco);
    @(posedge clock); #1;
    if (full) check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int d1, d2, nd;
    logic [19:0] ra, rb;
    logic        rci;
    logic [20:0] rsum;

    // 1. reset held 3 cycles with start asserted
    reset = 1'b1; start = 1'b1; a = 20'hFFFFF; b = 20'h00001; ci = 1'b0;
`ifdef ADDER_MW_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0; start = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_s", s, 20'h0);
    check("rst_co", co, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_start_lost", busy, 1'b0);

    // 2. carry ripples across all words
    do_op("carry_ripple", 20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b1);

    // 3. back-to-back ops, start held
    @(posedge clock); #1;
    a = 20'h12345; b = 20'h0ABCD; ci = 1'b1; start = 1'b1;
    d1 = 0; d2 = 0;
    for (int c = 1; c <= 20 && d2 == 0; c++) begin
      @(posedge clock); #1;
      if (c == 7) start = 1'b0;
      if (done) begin
        if (d1 == 0) begin
          d1 = c;
          check("b2b_first_s", s, 20'h1CF13);
          check("b2b_first_co", co, 1'b0);
        end else begin
          d2 = c;
        end
      end
    end
    check("b2b_first_done", d1, 5);
    check("b2b_second_done", d2, 11);
    check("b2b_second_s", s, 20'h1CF13);

    // 4. start held 10 cycles -> exactly two ops
    @(posedge clock); #1;
    a = 20'h00001; b = 20'h00002; ci = 1'b0; start = 1'b1;
    nd = 0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clock); #1;
      if (c == 10) start = 1'b0;
      if (done) nd++;
    end
    check("hold_op_count", nd, 2);
    check("hold_s", s, 20'h00003);
    check("hold_co", co, 1'b0);
    check("hold_idle", busy, 1'b0);

    // 5. reset in second RUN cycle aborts the op
    @(posedge clock); #1;
    a = 20'hFFFFF; b = 20'h00001; ci = 1'b0; start = 1'b1;
    nd = 0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clock); #1;
      if (c == 1) start = 1'b0;
      if (c >= 2 && done) nd++;
      if (c == 2) reset = 1'b1;
      if (c == 3) begin
        reset = 1'b0;
        check("abort_s", s, 20'h0);
        check("abort_co", co, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_state", state_dbg, 2'd0);
      end
    end
    check("abort_no_done", nd, 0);
    do_op("after_abort", 20'h00005, 20'h00007, 1'b0, 1'b0, 20'h0000C, 1'b0, 1'b1);

`ifdef ADDER_MW_SUB_EN
    // 6. subtract mode
    do_op("sub_small", 20'h00010, 20'h00011, 1'b0, 1'b1, 20'hFFFFF, 1'b0, 1'b1);
    check("sub_small_ovf", ovf, 1'b0);
    do_op("sub_ovf", 20'h7FFFF, 20'hFFFFF, 1'b0, 1'b1, 20'h80000, 1'b0, 1'b1);
    check("sub_ovf_ovf", ovf, 1'b1);
`endif

    // random sweep against a full-width sum
    for (int i = 0; i < 1000; i++) begin
      ra   = 20'($urandom_range(20'hFFFFF, 0));
      rb   = 20'($urandom_range(20'hFFFFF, 0));
      rci  = 1'($urandom_range(1, 0));
      rsum = {1'b0, ra} + {1'b0, rb} + {20'h0, rci};
      do_op("rand", ra, rb, rci, 1'b0, rsum[19:0], rsum[20], 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
